// File: rtl/dmem_if.sv
// Data-memory request/grant/response bus between the MEM stage (master) and memory (slave).
interface dmem_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage data-memory handshake plus the MEM/WB writeback register driving the register file.
// Optional macro LOAD_EXT_EN adds ld_funct3 and RISC-V byte/halfword load extraction.
module mem_wb_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] store_data,
  input  logic [REGW-1:0] dest_reg,
  input  logic            reg_write,
  input  logic            mem_write,
  input  logic [1:0]      result_src,
`ifdef LOAD_EXT_EN
  input  logic [2:0]      ld_funct3,
`endif
  dmem_if.master          dmem,
  output logic            mem_stall,
  output logic            rf_we,
  output logic [REGW-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);
  typedef enum logic {IDLE = 1'b0, WAIT_RSP = 1'b1} state_t;

  state_t          state, state_next;
  logic            is_load, is_store, mem_op;
  logic            vld_p0;
  logic [XLEN-1:0] load_data_p0;
  logic [XLEN-1:0] wb_data_p0;

`ifdef LOAD_EXT_EN
  function automatic logic [XLEN-1:0] extract_load(input logic [XLEN-1:0] word,
                                                   input logic [1:0]      offset,
                                                   input logic [2:0]      funct3);
    logic        [7:0]      lane_b;
    logic        [15:0]     lane_h;
    logic signed [7:0]      lane_sb;
    logic signed [15:0]     lane_sh;
    logic signed [XLEN-1:0] ext;
    lane_b  = word[{offset, 3'b000} +: 8];
    lane_h  = word[{offset[1], 4'b0000} +: 16];
    lane_sb = lane_b;
    lane_sh = lane_h;
    case (funct3)
      3'b000:  ext = lane_sb;
      3'b001:  ext = lane_sh;
      3'b100:  ext = $signed({{(XLEN-8){1'b0}}, lane_b});
      3'b101:  ext = $signed({{(XLEN-16){1'b0}}, lane_h});
      default: ext = $signed(word);
    endcase
    return ext;
  endfunction

  assign load_data_p0 = extract_load(dmem.rdata, alu_out[1:0], ld_funct3);
`else
  assign load_data_p0 = dmem.rdata;
`endif

  assign is_load  = ex_valid & (result_src == 2'b01) & ~mem_write;
  assign is_store = ex_valid & mem_write;
  assign mem_op   = is_load | is_store;

  // Request only from IDLE; address/data come straight from the held EX/MEM bundle.
  assign dmem.req   = (state == IDLE) & mem_op;
  assign dmem.we    = is_store;
  assign dmem.addr  = alu_out;
  assign dmem.wdata = store_data;

  always_comb begin
    state_next = state;
    mem_stall  = 1'b0;
    case (state)
      IDLE: begin
        mem_stall = mem_op & ~(is_store & dmem.gnt);
        if (is_load && dmem.gnt) state_next = WAIT_RSP;
      end
      WAIT_RSP: begin
        mem_stall = ~dmem.rvalid;
        if (dmem.rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (result_src)
      2'b01:   wb_data_p0 = load_data_p0;
      2'b10:   wb_data_p0 = pc_plus4;
      default: wb_data_p0 = alu_out;
    endcase
  end

  assign vld_p0 = ex_valid & ~mem_stall;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // MEM/WB boundary: bubbles clear the write enable but keep index/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= vld_p0 & reg_write & (dest_reg != '0);
      if (vld_p0) begin
        rf_waddr <= dest_reg;
        rf_wdata <= wb_data_p0;
      end
    end
  end
endmodule
